// File: rtl/ram_port_ctrl.sv
// Front-end for a single-port synchronous RAM: fills every word with INIT_VALUE after reset,
// then forwards a valid/ready request stream and returns read data through a 2-entry response FIFO.
module ram_port_ctrl #(
  parameter int                    addr_width = 8,
  parameter int                    data_width = 8,
  parameter logic [data_width-1:0] INIT_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [addr_width-1:0] req_addr,
  input  logic [data_width-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [data_width-1:0] rsp_rdata,
  output logic                  init_done,
  output logic                  ram_we,
  output logic [addr_width-1:0] ram_addr,
  output logic [data_width-1:0] ram_data_in,
  input  logic [data_width-1:0] ram_data_out
);

  typedef enum logic {ST_INIT, ST_RUN} state_e;

  localparam logic [addr_width-1:0] LAST_ADDR = '1;

  state_e                  state_q, state_d;
  logic [addr_width-1:0]   cnt_q, cnt_d;
  logic                    rd_pending_q, rd_pending_d;
  logic [1:0]              count_q, count_d;
  logic [data_width-1:0]   head_q, head_d, tail_q, tail_d;
  logic                    pop, accept;
  logic [2:0]              occupancy;

  // A read occupies a slot from its accept cycle until it is popped, pending or buffered.
  assign rsp_valid = !rst && (count_q != 2'd0);
  assign rsp_rdata = rst ? '0 : head_q;
  assign init_done = !rst && (state_q == ST_RUN);
  assign pop       = rsp_valid && rsp_ready;
  assign occupancy = 3'(count_q) + 3'(rd_pending_q) - 3'(pop);
  assign req_ready = init_done && (occupancy < 3'd2);
  assign accept    = req_valid && req_ready;

  // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    rd_pending_d = 1'b0;
    ram_we       = 1'b0;
    ram_addr     = req_addr;
    ram_data_in  = req_wdata;
    case (state_q)
      ST_INIT: begin
        ram_we      = !rst;
        ram_addr    = cnt_q;
        ram_data_in = INIT_VALUE;
        cnt_d       = cnt_q + addr_width'(1);
        if (cnt_q == LAST_ADDR) state_d = ST_RUN;
      end
      ST_RUN: begin
        ram_we       = accept && req_we;
        rd_pending_d = accept && !req_we;
      end
      default: state_d = ST_INIT;
    endcase
  end

  // Head always holds the oldest response so rsp_rdata comes straight from a register.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    case ({rd_pending_q, pop})
      2'b10: begin
        if (count_q == 2'd0) head_d = ram_data_out;
        else                 tail_d = ram_data_out;
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        head_d  = tail_q;
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        if (count_q == 2'd1) begin
          head_d = ram_data_out;
        end else begin
          head_d = tail_q;
          tail_d = ram_data_out;
        end
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_INIT;
      cnt_q        <= '0;
      rd_pending_q <= 1'b0;
      count_q      <= 2'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rd_pending_q <= rd_pending_d;
      count_q      <= count_d;
    end
  end

  // NOTE: buffer storage is left unreset; count_q qualifies it and rsp_rdata is forced to 0 during rst.
  always_ff @(posedge clk) begin
    head_q <= head_d;
    tail_q <= tail_d;
  end

endmodule

// File: doc/ram_port_ctrl.md
Name: ram_port_ctrl

Overview:
- Front-end controller that sits directly upstream of the single-port synchronous RAM (registered read address, write-first, one access per cycle).
- After reset, zero-fills (INIT_VALUE-fills) every RAM word.
- Then accepts a valid/ready request stream of reads and writes and drives the RAM port.
- Collects read data into a 2-entry response buffer with a valid/ready handshake, so the client may stall without losing data or throughput.

Parameters:
- addr_width, 8, RAM address width; addressable words 0 .. 2^addr_width-1.
- data_width, 8, RAM word width.
- INIT_VALUE, 0, data_width-bit value written to every word during initialisation.

Ports:
- clk  input  1  clock; all state on posedge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  controller accepts request this cycle.
- req_we  input  1  1 = write, 0 = read.
- req_addr  input  addr_width  request address.
- req_wdata  input  data_width  write data.
- rsp_valid  output  1  read response available.
- rsp_ready  input  1  client consumes response.
- rsp_rdata  output  data_width  read data, head of response buffer.
- init_done  output  1  initialisation complete, stays 1 until next rst.
- ram_we  output  1  to RAM we.
- ram_addr  output  addr_width  to RAM addr.
- ram_data_in  output  data_width  to RAM data_in.
- ram_data_out  input  data_width  from RAM data_out; valid the cycle after the address edge.

Behaviour:
- States: INIT, RUN. rst forces INIT with init counter = 0, rd_pending = 0, buffer count = 0.
- While rst is high: req_ready=0, rsp_valid=0, rsp_rdata=0, init_done=0, ram_we=0.
- INIT: ram_we=1, ram_addr=counter, ram_data_in=INIT_VALUE, req_ready=0; counter increments each cycle.
- INIT exit: after the cycle writing address 2^addr_width-1, go to RUN and set init_done=1.
  - The first post-reset cycle is cycle 0, so req_ready can first be 1 in cycle 2^addr_width.
- RUN accept rule: accept = req_valid && req_ready.
  - req_ready = RUN && (count + rd_pending − (rsp_valid && rsp_ready)) < 2.
  - Combinational path rsp_ready -> req_ready is permitted; no path req_valid -> req_ready.
- RUN RAM drive: ram_addr = req_addr, ram_data_in = req_wdata, ram_we = accept && req_we.
  - ram_addr is don't-care when not accepting.
- Accepted write: RAM updated at that edge; no response generated.
- Accepted read: rd_pending=1 next cycle. In that cycle ram_data_out is pushed into the buffer at the following edge.
  - rsp_valid is asserted 2 cycles after the accept cycle (accept in cycle N -> rsp_valid in N+2).
  - The buffer is never bypassed.
- Response buffer: 2-entry FIFO. Responses are returned in request order.
  - rsp_rdata is the head entry and is registered. It holds stable while rsp_valid && !rsp_ready.
  - Push and pop in the same cycle are allowed; count is unchanged.
- Throughput: back-to-back reads with rsp_ready held 1 give one response per cycle.
  - With rsp_ready=0, at most 2 reads are outstanding (buffered plus pending); req_ready then drops.
  - Writes are throttled by the same rule and are not blocked by type.
- Ordering: a write accepted in cycle N, then a read of the same address in N+1, returns the new data.
- Address wrap: addresses are modulo 2^addr_width; no out-of-range access exists.
- rst mid-operation (RUN or INIT) discards all pending and buffered responses and restarts INIT from address 0.
  - Any write already issued to the RAM remains, but is overwritten by INIT.
- Requests presented during INIT are not accepted; req_valid may be held high without effect.

Test Plan:
- Reset then idle, addr_width=4 -> ram_we=1 for exactly 16 cycles at addresses 0..15 with data 0x00; init_done and req_ready rise in cycle 16.
- After init, read addresses 3 and 9 -> two responses, both 0x00 (INIT_VALUE), each 2 cycles after accept; INIT_VALUE=0xA5 build returns 0xA5.
- Write 0x3C to addr 0x12 in cycle N, read 0x12 in cycle N+1 -> rsp_rdata=0x3C in cycle N+3.
- 8 back-to-back reads of addr 0..7 (preloaded addr*0x11), rsp_ready=1 -> req_ready stays 1, responses 0x00,0x11,…,0x77 on consecutive cycles.
- Same 8 reads with rsp_ready=0 for 10 cycles -> exactly 2 reads accepted, req_ready=0, rsp_rdata=0x00 held stable.
  - Then rsp_ready=1 -> all 8 responses delivered in order, none lost or duplicated.
- Assert rst for one cycle with 2 responses buffered -> rsp_valid=0 the next cycle, init_done=0, INIT reruns over all 2^addr_width addresses; no stale response appears afterwards.
